qracc_sram_arbiter: RTL

QRACC_SRAM_ARBITER -- requirements
Module: qracc_sram_arbiter

---
 rtl/qracc_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 24 ++
 rtl/qracc_sram_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/qracc_pkg.sv
// qracc_pkg: shared SRAM request/response types and geometry for the QRAcc
// memory subsystem.
//   numRows / numCols   : SRAM geometry (row count, word width)
//   to_sram_t           : request from a master toward the SRAM
//   from_sram_t         : response from the SRAM toward a master
//   qracc_arb_state_t   : state encoding of the two-master SRAM arbiter
package qracc_pkg;

  localparam int numRows = 128;
  localparam int numCols = 32;
  localparam int ADDR_W  = $clog2(numRows);

  typedef struct packed {
    logic              rq_valid_i;
    logic              rq_wr_i;     // 1 = write, 0 = read
    logic [ADDR_W-1:0] addr_i;
    logic [numCols-1:0] wr_data_i;
  } to_sram_t;

  typedef struct packed {
    logic               rq_ready_o;
    logic               rd_valid_o;
    logic [numCols-1:0] rd_data_o;
  } from_sram_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT_RD
  } qracc_arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: purely combinational two-way round-robin selector.
//   valid_i[1:0] : request valid per requester
//   last_i       : index of the requester granted by the last accepted handshake
//   gnt_o        : index of the selected requester (0 when nobody is valid)
//   any_o        : at least one requester is valid
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       any_o
);

  always_comb begin
    any_o = valid_i[0] | valid_i[1];
    gnt_o = 1'b0;
    if (valid_i[0] && valid_i[1]) begin
      // On a tie, favour whoever did not win last time.
      gnt_o = ~last_i;
    end else if (valid_i[1]) begin
      gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/qracc_sram_arbiter.sv
// qracc_sram_arbiter: shares one SRAM slave between two requesters.
// Writes stream through at one per cycle with round-robin on ties; a read
// blocks the slave port until its rd_valid returns or a timeout expires.
//
// Ports:
//   clk        : clock, rising edge
//   nrst       : asynchronous active-low reset
//   m_req_i[i] : request from requester i
//   m_rsp_o[i] : ready / rd_valid / rd_data toward requester i
//   s_req_o    : request forwarded to the SRAM slave
//   s_rsp_i    : SRAM slave response
//   err_o      : sticky error (read timeout or stray rd_valid)
//   gnt_cnt_o  : per-requester accepted-handshake counters, saturating
//                (present only when QRACC_SRAM_ARB_PERF_EN is defined)
module qracc_sram_arbiter
  import qracc_pkg::*;
#(
  parameter int numRows   = qracc_pkg::numRows,
  parameter int numCols   = qracc_pkg::numCols,
  parameter int rdTimeout = 64
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  to_sram_t       [1:0] m_req_i,
  output from_sram_t     [1:0] m_rsp_o,
  output to_sram_t             s_req_o,
  input  from_sram_t           s_rsp_i,
  output logic                 err_o
`ifdef QRACC_SRAM_ARB_PERF_EN
  ,
  output logic [1:0][15:0]     gnt_cnt_o
`endif
);

  localparam int AW   = $clog2(numRows);
  localparam int TO_W = $clog2(rdTimeout + 1);

  qracc_arb_state_t state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [1:0]         valid_vec;
  logic               gnt;
  logic               any_gnt;
  logic               fwd_valid;
  logic               hs;
  logic               sel_wr;
  logic [AW-1:0]      sel_addr;
  logic [numCols-1:0] sel_wdata;
  logic [numCols-1:0] rd_data;

  assign valid_vec = {m_req_i[1].rq_valid_i, m_req_i[0].rq_valid_i};

  rr_arbiter2 u_rr (
    .valid_i (valid_vec),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .any_o   (any_gnt)
  );

  // Request forwarding and per-requester responses.
  always_comb begin
    sel_wr    = m_req_i[gnt].rq_wr_i;
    sel_addr  = m_req_i[gnt].addr_i;
    sel_wdata = m_req_i[gnt].wr_data_i;
    rd_data   = s_rsp_i.rd_data_o;

    // Gating on nrst keeps every valid/ready low while reset is held.
    fwd_valid = nrst && (state_q == S_IDLE) && any_gnt;
    hs        = fwd_valid && s_rsp_i.rq_ready_o;

    s_req_o.rq_valid_i = fwd_valid;
    s_req_o.rq_wr_i    = sel_wr;
    s_req_o.addr_i     = sel_addr;
    s_req_o.wr_data_i  = sel_wdata;

    m_rsp_o[0].rq_ready_o = fwd_valid && (gnt == 1'b0) && s_rsp_i.rq_ready_o;
    m_rsp_o[1].rq_ready_o = fwd_valid && (gnt == 1'b1) && s_rsp_i.rq_ready_o;

    m_rsp_o[0].rd_valid_o = nrst && (state_q == S_WAIT_RD) && (owner_q == 1'b0)
                            && s_rsp_i.rd_valid_o;
    m_rsp_o[1].rd_valid_o = nrst && (state_q == S_WAIT_RD) && (owner_q == 1'b1)
                            && s_rsp_i.rd_valid_o;

    m_rsp_o[0].rd_data_o = rd_data;
    m_rsp_o[1].rd_data_o = rd_data;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        // Nothing is outstanding, so any rd_valid here is stray.
        if (s_rsp_i.rd_valid_o) begin
          err_d = 1'b1;
        end
        if (hs) begin
          last_d = gnt;
          if (!sel_wr) begin
            state_d = S_WAIT_RD;
            owner_d = gnt;
            cnt_d   = '0;
          end
        end
      end

      S_WAIT_RD: begin
        if (s_rsp_i.rd_valid_o) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
          // Counter reaches rdTimeout on this edge: give up on the read.
          if (cnt_q == TO_W'(rdTimeout - 1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef QRACC_SRAM_ARB_PERF_EN
  logic [1:0][15:0] gnt_cnt_q, gnt_cnt_d;

  always_comb begin
    gnt_cnt_d = gnt_cnt_q;
    if (hs && (gnt_cnt_q[gnt] != 16'hFFFF)) begin
      gnt_cnt_d[gnt] = gnt_cnt_q[gnt] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gnt_cnt_q <= '0;
    end else begin
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  assign gnt_cnt_o = gnt_cnt_q;
`endif

endmodule
